// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that shares one parallel-to-serial serializer between NREQ requesters.
// Latches the winner's word/framesize, sequences clear/load/send, and reports done or timeout.
module serial_tx_scheduler #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*WIDTH-1:0]   req_size,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    busy,
    output logic                    ser_reset_n,
    output logic                    ser_enable,
    output logic                    ser_load_send,
    output logic [WIDTH-1:0]        ser_parallel,
    output logic [WIDTH-1:0]        ser_framesize,
    input  logic                    ser_complete
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = WIDTH + $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SEND, DONE} state_t;

    state_t            state, state_d;
    logic [PW-1:0]     ptr, ptr_d;
    logic [PW-1:0]     gidx, gidx_d;
    logic [PW-1:0]     win;
    logic              found;
    logic [NREQ-1:0]   grant_d, done_d;
    logic              err_d, busy_d, ser_rst_q, ser_rst_d, ser_enable_d, ser_load_send_d;
    logic [WIDTH-1:0]  ser_parallel_d, ser_framesize_d;
    logic [WW-1:0]     wdog, wdog_d, wdog_inc, wdog_limit;
    logic [WIDTH-1:0]  data_arr [NREQ];
    logic [WIDTH-1:0]  size_arr [NREQ];

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_slice
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
        assign size_arr[i] = req_size[i*WIDTH +: WIDTH];
    end

    // The serializer clear must follow reset immediately, not wait for a clock.
    assign ser_reset_n = rst_n & ser_rst_q;

    assign wdog_limit = WW'(ser_framesize) + WW'(1) + WW'(TIMEOUT);
    assign wdog_inc   = (wdog == '1) ? wdog : wdog + WW'(1);

    // Round-robin search starting just above the last winner.
    always_comb begin
        found = 1'b0;
        win   = gidx;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!found && req[PW'((32'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                win   = PW'((32'(ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d         = state;
        ptr_d           = ptr;
        gidx_d          = gidx;
        grant_d         = grant;
        done_d          = '0;
        err_d           = 1'b0;
        ser_parallel_d  = ser_parallel;
        ser_framesize_d = ser_framesize;
        wdog_d          = wdog;
        case (state)
            IDLE: begin
                wdog_d = '0;
                if (found) begin
                    state_d         = CLEAR;
                    gidx_d          = win;
                    grant_d         = NREQ'(1) << win;
                    ser_parallel_d  = data_arr[win];
                    ser_framesize_d = size_arr[win];
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                state_d = SEND;
                wdog_d  = '0;
            end
            SEND: begin
                wdog_d = wdog_inc;
                if (ser_complete) begin
                    state_d = DONE;
                    done_d  = grant;
                end else if (wdog_inc == wdog_limit) begin
                    state_d = DONE;
                    done_d  = grant;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = gidx;
            end
            default: state_d = IDLE;
        endcase
        // Serializer controls are decoded from the state being entered so they align with it.
        busy_d          = (state_d != IDLE);
        ser_rst_d       = (state_d != CLEAR);
        ser_enable_d    = (state_d == LOAD) || (state_d == SEND);
        ser_load_send_d = (state_d == SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= PW'(NREQ - 1);
            gidx          <= '0;
            grant         <= '0;
            done          <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            ser_rst_q     <= 1'b1;
            ser_enable    <= 1'b0;
            ser_load_send <= 1'b0;
            ser_parallel  <= '0;
            ser_framesize <= '0;
            wdog          <= '0;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            gidx          <= gidx_d;
            grant         <= grant_d;
            done          <= done_d;
            err           <= err_d;
            busy          <= busy_d;
            ser_rst_q     <= ser_rst_d;
            ser_enable    <= ser_enable_d;
            ser_load_send <= ser_load_send_d;
            ser_parallel  <= ser_parallel_d;
            ser_framesize <= ser_framesize_d;
            wdog          <= wdog_d;
        end
    end

endmodule
